// File: rtl/byte_dec_display_pkg.sv
// Shared types and constants for the byte-to-decimal 7-segment display block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
//
// Contents: converter state enum, 7-segment decode constants, digit count,
// and a helper that maps one BCD digit to its segment pattern.
package byte_dec_display_pkg;

    typedef enum logic [1:0] {
        CONV_IDLE  = 2'd0,
        CONV_SHIFT = 2'd1,
        CONV_LOAD  = 2'd2
    } conv_state_t;

    localparam int DIGIT_COUNT = 3;

    // Segment patterns, bit order g,f,e,d,c,b,a (bit 0 = a), active-high.
    localparam logic [6:0] SEG_DIG_0 = 7'h3F;
    localparam logic [6:0] SEG_DIG_1 = 7'h06;
    localparam logic [6:0] SEG_DIG_2 = 7'h5B;
    localparam logic [6:0] SEG_DIG_3 = 7'h4F;
    localparam logic [6:0] SEG_DIG_4 = 7'h66;
    localparam logic [6:0] SEG_DIG_5 = 7'h6D;
    localparam logic [6:0] SEG_DIG_6 = 7'h7D;
    localparam logic [6:0] SEG_DIG_7 = 7'h07;
    localparam logic [6:0] SEG_DIG_8 = 7'h7F;
    localparam logic [6:0] SEG_DIG_9 = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] pattern;
        pattern = SEG_BLANK;
        case (bcd)
            4'd0:    pattern = SEG_DIG_0;
            4'd1:    pattern = SEG_DIG_1;
            4'd2:    pattern = SEG_DIG_2;
            4'd3:    pattern = SEG_DIG_3;
            4'd4:    pattern = SEG_DIG_4;
            4'd5:    pattern = SEG_DIG_5;
            4'd6:    pattern = SEG_DIG_6;
            4'd7:    pattern = SEG_DIG_7;
            4'd8:    pattern = SEG_DIG_8;
            4'd9:    pattern = SEG_DIG_9;
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one byte in, three BCD digits out.
// Latency: accept edge E0 -> load_vld high during the cycle ending at edge E9.
// Backpressure: in_ready low while converting; a byte equal to the last loaded one is dropped.
//
// Ports: clk, rst (async active-high); in_valid/in_data/in_ready upstream
// handshake; busy / busy_nxt (current / next-cycle conversion status);
// load_vld + bcd_dat present the finished digits {hundreds,tens,ones}.
module bin2bcd_seq
    import byte_dec_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        busy,
    output logic        busy_nxt,
    output logic        load_vld,
    output logic [11:0] bcd_dat
);

    conv_state_t state_q;
    conv_state_t state_nxt;

    logic [7:0]  bin_q;
    logic [7:0]  src_q;
    logic [7:0]  last_q;
    logic [11:0] bcd_q;
    logic [11:0] bcd_adj;
    logic [2:0]  iter_q;
    logic        accept;

    assign in_ready = (state_q == CONV_IDLE);
    assign busy     = (state_q != CONV_IDLE);
    assign busy_nxt = (state_nxt != CONV_IDLE);
    assign load_vld = (state_q == CONV_LOAD);
    assign bcd_dat  = bcd_q;

    // A repeat of the value already on display is swallowed without a conversion.
    assign accept = in_valid && in_ready && (in_data != last_q);

    // Add-3 correction applied to every nibble before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int n = 0; n < DIGIT_COUNT; n++) begin
            if (bcd_q[n*4 +: 4] >= 4'd5) begin
                bcd_adj[n*4 +: 4] = bcd_q[n*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            CONV_IDLE:  if (accept) state_nxt = CONV_SHIFT;
            CONV_SHIFT: if (iter_q == 3'd7) state_nxt = CONV_LOAD;
            CONV_LOAD:  state_nxt = CONV_IDLE;
            default:    state_nxt = CONV_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CONV_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= 8'd0;
            src_q  <= 8'd0;
            last_q <= 8'd0;
            bcd_q  <= 12'd0;
            iter_q <= 3'd0;
        end else begin
            case (state_q)
                CONV_IDLE: begin
                    if (accept) begin
                        bin_q  <= in_data;
                        src_q  <= in_data;
                        bcd_q  <= 12'd0;
                        iter_q <= 3'd0;
                    end
                end
                CONV_SHIFT: begin
                    {bcd_q, bin_q} <= {bcd_adj[10:0], bin_q, 1'b0};
                    iter_q         <= iter_q + 3'd1;
                end
                CONV_LOAD: begin
                    // Remembered only once the digits actually reach the display.
                    last_q <= src_q;
                end
                default: begin
                    iter_q <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/byte_dec_display.sv
// Byte to 3-digit decimal multiplexed 7-segment display driver.
// Latency: accept at E0 -> display register at E9 -> seg/dig_en one edge after scan reaches digit.
// Backpressure: in_ready low for 9 cycles per conversion; in_valid ignored meanwhile.
//
// Ports: clk, rst (async active-high); in_valid/in_data/in_ready byte input;
// seg (g..a), dp, dig_en (one-hot ones/tens/hundreds), busy.
module byte_dec_display
    import byte_dec_display_pkg::*;
#(
    parameter int REFRESH_DIV = 1024
)
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic [6:0] seg,
    output logic       dp,
    output logic [2:0] dig_en,
    output logic       busy
);

    logic        busy_nxt;
    logic        load_vld;
    logic [11:0] bcd_dat;

    logic [11:0] disp_q;
    logic [15:0] refresh_q;
    logic [1:0]  dig_idx_q;

    logic [3:0]  ones;
    logic [3:0]  tens;
    logic [3:0]  hund;
    logic [6:0]  seg_nxt;
    logic [2:0]  dig_en_nxt;
    logic        dp_nxt;
    logic        refresh_wrap;

    bin2bcd_seq u_conv (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .busy_nxt (busy_nxt),
        .load_vld (load_vld),
        .bcd_dat  (bcd_dat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q <= 12'd0;
        end else if (load_vld) begin
            disp_q <= bcd_dat;
        end
    end

    assign refresh_wrap = (refresh_q == 16'(REFRESH_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= 16'd0;
            dig_idx_q <= 2'd0;
        end else if (refresh_wrap) begin
            refresh_q <= 16'd0;
            dig_idx_q <= (dig_idx_q == 2'(DIGIT_COUNT - 1)) ? 2'd0 : dig_idx_q + 2'd1;
        end else begin
            refresh_q <= refresh_q + 16'd1;
        end
    end

    assign ones = disp_q[3:0];
    assign tens = disp_q[7:4];
    assign hund = disp_q[11:8];

    // Leading-zero blanking: the digit is still enabled, only its segments go dark.
    always_comb begin
        seg_nxt    = seg_decode(ones);
        dig_en_nxt = 3'b001;
        case (dig_idx_q)
            2'd0: begin
                seg_nxt    = seg_decode(ones);
                dig_en_nxt = 3'b001;
            end
            2'd1: begin
                seg_nxt    = (hund == 4'd0 && tens == 4'd0) ? SEG_BLANK : seg_decode(tens);
                dig_en_nxt = 3'b010;
            end
            2'd2: begin
                seg_nxt    = (hund == 4'd0) ? SEG_BLANK : seg_decode(hund);
                dig_en_nxt = 3'b100;
            end
            default: begin
                seg_nxt    = seg_decode(ones);
                dig_en_nxt = 3'b001;
            end
        endcase
    end

    // Uses next-cycle busy so the registered dp lines up with the live busy flag.
    assign dp_nxt = (dig_idx_q == 2'd0) && busy_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg    <= SEG_DIG_0;
            dig_en <= 3'b001;
            dp     <= 1'b0;
        end else begin
            seg    <= seg_nxt;
            dig_en <= dig_en_nxt;
            dp     <= dp_nxt;
        end
    end

endmodule

// File: tb/tb_byte_dec_display.sv
// Directed self-checking bench for byte_dec_display with a short refresh period.
// Latency: checks 9-cycle busy window and scan timing of 4 cycles per digit.
// Backpressure: drives in_valid held high during conversion to confirm it is ignored.
module tb_byte_dec_display;

    localparam int RDIV = 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] dig_en;
    logic       busy;

    int checks;
    int failures;

    byte_dec_display #(.REFRESH_DIV(RDIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .seg      (seg),
        .dp       (dp),
        .dig_en   (dig_en),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_seg"},      32'(seg),      32'h3F);
        check_eq({tag, "_dig_en"},   32'(dig_en),   32'h1);
        check_eq({tag, "_dp"},       32'(dp),       32'h0);
        check_eq({tag, "_busy"},     32'(busy),     32'h0);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'h1);
    endtask

    // Present a byte for one edge, then count cycles with in_ready low.
    task automatic send_byte(input string tag, input logic [7:0] b);
        int lo;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lo = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
            lo++;
            check_eq({tag, "_busy_conv"}, 32'(busy), 32'h1);
            check_eq({tag, "_dp_conv"}, 32'(dp), 32'(dig_en[0] & busy));
        end
        check_eq({tag, "_ready_low_cycles"}, lo, 9);
        check_eq({tag, "_busy_done"}, 32'(busy), 32'h0);
    endtask

    // Sync to the hundreds->ones wrap, then check one full scan frame.
    task automatic scan_check(input string tag, input logic [6:0] exp_h,
                              input logic [6:0] exp_t, input logic [6:0] exp_o);
        logic [2:0] prev;
        logic [2:0] exp_en;
        logic [6:0] exp_seg;
        bit         found;
        found = 1'b0;
        prev  = 3'b001;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (prev == 3'b100 && dig_en == 3'b001) begin
                found = 1'b1;
                break;
            end
            prev = dig_en;
        end
        check_eq({tag, "_sync"}, 32'(found), 32'h1);
        if (found) begin
            for (int k = 0; k < 3 * RDIV; k++) begin
                if (k > 0) @(negedge clk);
                exp_en  = 3'(1 << (k / RDIV));
                exp_seg = (k / RDIV == 0) ? exp_o : ((k / RDIV == 1) ? exp_t : exp_h);
                check_eq({tag, "_dig_en"}, 32'(dig_en), 32'(exp_en));
                check_eq({tag, "_seg"},    32'(seg),    32'(exp_seg));
                check_eq({tag, "_dp"},     32'(dp),     32'h0);
            end
        end
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;

        repeat (2) @(negedge clk);
        check_reset_outputs("reset_init");
        rst = 1'b0;

        // 255 -> 2,5,5
        send_byte("ff", 8'hFF);
        scan_check("ff", 7'h5B, 7'h6D, 7'h6D);

        // 7 -> hundreds and tens blanked
        send_byte("x07", 8'h07);
        scan_check("x07", 7'h00, 7'h00, 7'h07);

        // 42, then a repeat of 42 which must not start a conversion
        send_byte("x2a", 8'h2A);
        scan_check("x2a", 7'h00, 7'h66, 7'h5B);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h2A;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("dup_ready", 32'(in_ready), 32'h1);
        check_eq("dup_busy",  32'(busy),     32'h0);
        repeat (3) begin
            @(negedge clk);
            check_eq("dup_ready_hold", 32'(in_ready), 32'h1);
            check_eq("dup_busy_hold",  32'(busy),     32'h0);
        end
        scan_check("dup", 7'h00, 7'h66, 7'h5B);

        // 0x80 aborted by reset during the 4th shift cycle
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h80;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check_eq("abort_busy_pre", 32'(busy), 32'h1);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("abort_async");
        @(negedge clk);
        check_reset_outputs("abort_hold");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("abort_ready_after", 32'(in_ready), 32'h1);
        scan_check("abort", 7'h00, 7'h00, 7'h3F);

        send_byte("x01", 8'h01);
        scan_check("x01", 7'h00, 7'h00, 7'h06);

        // in_valid held with changing data: only 0x93 (147) is captured
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h93;
        @(posedge clk);
        #1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) begin
                in_valid = 1'b0;
                break;
            end
            n++;
            in_data = 8'h10 + 8'(n);
        end
        in_valid = 1'b0;
        check_eq("hold_ready_low_cycles", n, 9);
        scan_check("hold", 7'h06, 7'h66, 7'h07);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
